// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the codeword/nibble widths, Hamming(7,4) bit positions, the receiver state
// encoding reported by the receiver, and the controller watchdog state encoding.
package uart_pkg;

  localparam int unsigned CodeW   = 7;
  localparam int unsigned NibbleW = 4;

  // Hamming(7,4) layout: parity bits at power-of-two positions (1-based 1, 2, 4).
  localparam int unsigned PosP1 = 0;
  localparam int unsigned PosP2 = 1;
  localparam int unsigned PosD1 = 2;
  localparam int unsigned PosP4 = 3;
  localparam int unsigned PosD2 = 4;
  localparam int unsigned PosD3 = 5;
  localparam int unsigned PosD4 = 6;

  typedef enum logic [1:0] {
    RxIdle  = 2'b00,
    RxStart = 2'b01,
    RxData  = 2'b10,
    RxStop  = 2'b11
  } rx_state_e;

  typedef enum logic {
    WdRun  = 1'b0,
    WdHold = 1'b1
  } wd_state_e;

endpackage

// File: rtl/hamming74_decode.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
// Ports:
//   code      in  7  received codeword c[6:0]
//   data      out 4  corrected nibble {d4,d3,d2,d1}
//   syndrome  out 3  {s4,s2,s1}; nonzero gives the 1-based position of the flipped bit
//   corrected out 1  a bit was flipped (double errors miscorrect silently)
module hamming74_decode
  import uart_pkg::*;
(
  input  logic [CodeW-1:0]   code,
  output logic [NibbleW-1:0] data,
  output logic [2:0]         syndrome,
  output logic               corrected
);

  logic             w_s1, w_s2, w_s4;
  logic [CodeW-1:0] w_fixed;

  assign w_s1 = code[PosP1] ^ code[PosD1] ^ code[PosD2] ^ code[PosD4];
  assign w_s2 = code[PosP2] ^ code[PosD1] ^ code[PosD3] ^ code[PosD4];
  assign w_s4 = code[PosP4] ^ code[PosD2] ^ code[PosD3] ^ code[PosD4];

  assign syndrome  = {w_s4, w_s2, w_s1};
  assign corrected = (syndrome != 3'd0);

  always_comb begin
    w_fixed = code;
    if (corrected) begin
      w_fixed[syndrome - 3'd1] = ~code[syndrome - 3'd1];
    end
  end

  assign data = {w_fixed[PosD4], w_fixed[PosD3], w_fixed[PosD2], w_fixed[PosD1]};

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer for the 8x-oversampled Hamming(7,4) UART receiver.
// Generates the oversample strobe, captures codewords on the rising edge of the
// receiver's valid flag, corrects them, buffers nibbles in a FIFO and resets a
// receiver that lingers outside IDLE for too long.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               freezes divider and watchdog when low
//   rx_data_in/rx_state_in/rx_valid_in   receiver codeword, state, valid level
//   rx_ena_out        registered oversample strobe
//   rx_rst_n_out      registered active-low receiver reset
//   out_data/out_valid/out_ready         FIFO head with ready/valid handshake
//   err_corrected     pulse: stored word had a corrected bit
//   overflow/timeout  sticky flags, cleared by clr (a coincident set wins)
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 96
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [CodeW-1:0]   rx_data_in,
  input  logic [1:0]         rx_state_in,
  input  logic               rx_valid_in,
  output logic               rx_ena_out,
  output logic               rx_rst_n_out,
  output logic [NibbleW-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_corrected,
  output logic               overflow,
  output logic               timeout,
  input  logic               clr
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned WdW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Divider: strobe is the registered terminal count.
  logic [DivW-1:0] r_div_cnt;
  logic            r_strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= ena && (r_div_cnt == DivW'(CLK_DIV - 1));
      if (ena) begin
        r_div_cnt <= (r_div_cnt == DivW'(CLK_DIV - 1)) ? '0 : r_div_cnt + DivW'(1);
      end
    end
  end

  assign rx_ena_out = r_strobe;

  // Watchdog FSM.
  wd_state_e       r_wd_state, w_wd_state_d;
  logic [WdW-1:0]  r_wd_cnt, w_wd_cnt_d;
  logic [DivW-1:0] r_hold_cnt, w_hold_cnt_d;
  logic            r_rx_rst_n, w_rx_rst_n_d;
  logic            w_timeout_set;

  always_comb begin
    w_wd_state_d  = r_wd_state;
    w_wd_cnt_d    = r_wd_cnt;
    w_hold_cnt_d  = r_hold_cnt;
    w_rx_rst_n_d  = 1'b1;
    w_timeout_set = 1'b0;
    unique case (r_wd_state)
      WdRun: begin
        if (r_strobe) begin
          if (rx_state_in == RxIdle) begin
            w_wd_cnt_d = '0;
          end else if (r_wd_cnt == WdW'(TIMEOUT - 1)) begin
            w_wd_state_d  = WdHold;
            w_wd_cnt_d    = '0;
            w_hold_cnt_d  = '0;
            w_rx_rst_n_d  = 1'b0;
            w_timeout_set = 1'b1;
          end else begin
            w_wd_cnt_d = r_wd_cnt + WdW'(1);
          end
        end
      end
      WdHold: begin
        // Entry cycle plus CLK_DIV-1 further cycles keeps reset low CLK_DIV cycles.
        if (r_hold_cnt == DivW'(CLK_DIV - 1)) begin
          w_wd_state_d = WdRun;
        end else begin
          w_hold_cnt_d = r_hold_cnt + DivW'(1);
          w_rx_rst_n_d = 1'b0;
        end
      end
      default: w_wd_state_d = WdRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_state <= WdRun;
      r_wd_cnt   <= '0;
      r_hold_cnt <= '0;
      r_rx_rst_n <= 1'b1;
    end else begin
      r_wd_state <= w_wd_state_d;
      r_wd_cnt   <= w_wd_cnt_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_rx_rst_n <= w_rx_rst_n_d;
    end
  end

  assign rx_rst_n_out = r_rx_rst_n;

  // Capture and decode.
  logic               r_valid_prev;
  logic [NibbleW-1:0] w_nibble;
  logic [2:0]         w_syndrome;
  logic               w_corrected;
  logic               w_unused_syndrome;

  hamming74_decode u_decode (
    .code      (rx_data_in),
    .data      (w_nibble),
    .syndrome  (w_syndrome),
    .corrected (w_corrected)
  );

  assign w_unused_syndrome = ^w_syndrome;

  // FIFO.
  logic [NibbleW-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]    r_wr_ptr, r_rd_ptr;
  logic               w_full, w_empty, w_pop, w_capture, w_push_ok, w_drop;
  logic               r_err, r_overflow, r_timeout;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                     (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign w_capture = rx_valid_in & ~r_valid_prev & (r_wd_state == WdRun);
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;
  assign out_data  = r_mem[r_rd_ptr[AddrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr[AddrW-1:0]] <= w_nibble;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_prev <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_err        <= 1'b0;
      r_overflow   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_valid_prev <= rx_valid_in;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_err      <= w_push_ok & w_corrected;
      r_overflow <= w_drop ? 1'b1 : (clr ? 1'b0 : r_overflow);
      r_timeout  <= w_timeout_set ? 1'b1 : (clr ? 1'b0 : r_timeout);
    end
  end

  assign err_corrected = r_err;
  assign overflow      = r_overflow;
  assign timeout       = r_timeout;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with default parameters
// (CLK_DIV=4, DEPTH=4, TIMEOUT=96).
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [6:0] rx_data_in = '0;
  logic [1:0] rx_state_in = '0;
  logic       rx_valid_in = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr = 1'b0;
  logic       rx_ena_out, rx_rst_n_out, out_valid, err_corrected, overflow, timeout;
  logic [3:0] out_data;

  uart_rx_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .rx_data_in    (rx_data_in),
    .rx_state_in   (rx_state_in),
    .rx_valid_in   (rx_valid_in),
    .rx_ena_out    (rx_ena_out),
    .rx_rst_n_out  (rx_rst_n_out),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err_corrected (err_corrected),
    .overflow      (overflow),
    .timeout       (timeout),
    .clr           (clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int err_total = 0;

  always @(negedge clk) if (err_corrected === 1'b1) err_total = err_total + 1;

  typedef struct {
    logic [6:0] code;
    logic [3:0] nib;
    int         corr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] code);
    rx_data_in  = code;
    rx_valid_in = 1'b1;
    repeat (8) step();
    rx_valid_in = 1'b0;
    repeat (2) step();
  endtask

  task automatic pop_expect(input string name, input logic [3:0] exp);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_data"}, out_data, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int e0, strobes, low, rst_min;
    logic exp_strobe;

    vecs[0] = '{7'h55, 4'hB, 0};
    vecs[1] = '{7'h45, 4'hB, 1};  // d2 flipped
    vecs[2] = '{7'h00, 4'h0, 0};
    vecs[3] = '{7'h7F, 4'hF, 0};
    vecs[4] = '{7'h01, 4'h0, 1};  // p1 flipped
    vecs[5] = '{7'h7E, 4'hF, 1};  // p1 flipped
    vecs[6] = '{7'h1E, 4'h3, 0};
    vecs[7] = '{7'h5E, 4'h3, 1};  // d4 flipped
    vecs[8] = '{7'h57, 4'hB, 1};  // p2 flipped
    vecs[9] = '{7'h56, 4'hA, 1};  // p1+p2 flipped: miscorrects d1

    // Reset values
    #12;
    chk("rst_ena_out", rx_ena_out, 1'b0);
    chk("rst_rx_rst_n", rx_rst_n_out, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_err", err_corrected, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_timeout", timeout, 1'b0);

    // Strobe after edges 4, 8, 12; ena low over edges 13..15 pushes the next to 19
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      ena = !(i >= 13 && i <= 15);
      step();
      exp_strobe = (i == 4 || i == 8 || i == 12 || i == 19);
      chk($sformatf("strobe_edge%0d", i), rx_ena_out, exp_strobe);
    end
    ena = 1'b1;

    // Decode table
    for (int v = 0; v < 10; v++) begin
      e0 = err_total;
      send(vecs[v].code);
      chk($sformatf("dec%0d_err_pulses", v), err_total - e0, vecs[v].corr);
      pop_expect($sformatf("dec%0d", v), vecs[v].nib);
      chk($sformatf("dec%0d_empty", v), out_valid, 1'b0);
    end

    // Overflow: five words into a four-deep FIFO, the fifth is dropped
    send(7'h1E);
    send(7'h55);
    send(7'h00);
    send(7'h7F);
    chk("ovf_not_yet", overflow, 1'b0);
    e0 = err_total;
    send(7'h5E);
    chk("ovf_drop_no_err", err_total - e0, 0);
    chk("ovf_set", overflow, 1'b1);
    pop_expect("ovf_pop0", 4'h3);
    pop_expect("ovf_pop1", 4'hB);
    pop_expect("ovf_pop2", 4'h0);
    pop_expect("ovf_pop3", 4'hF);
    chk("ovf_drained", out_valid, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf_clr", overflow, 1'b0);

    // Full FIFO, push and pop in the same cycle
    send(7'h1E);
    send(7'h55);
    send(7'h00);
    send(7'h7F);
    rx_data_in  = 7'h56;
    rx_valid_in = 1'b1;
    out_ready   = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (7) step();
    rx_valid_in = 1'b0;
    repeat (2) step();
    chk("full_pp_no_ovf", overflow, 1'b0);
    pop_expect("full_pp0", 4'hB);
    pop_expect("full_pp1", 4'h0);
    pop_expect("full_pp2", 4'hF);
    pop_expect("full_pp3", 4'hA);
    chk("full_pp_empty", out_valid, 1'b0);

    // Watchdog fires on the 96th non-idle strobe
    rx_state_in = 2'b11;
    strobes = rx_ena_out ? 1 : 0;
    for (int c = 0; c < 2000 && rx_rst_n_out; c++) begin
      step();
      if (rx_ena_out) strobes++;
    end
    chk("wd_fired", rx_rst_n_out, 1'b0);
    chk("wd_strobes", strobes, 96);
    chk("wd_timeout", timeout, 1'b1);
    // A valid edge during HOLD must not be captured
    rx_data_in  = 7'h55;
    rx_valid_in = 1'b1;
    low = 1;
    for (int c = 0; c < 20 && !rx_rst_n_out; c++) begin
      step();
      if (!rx_rst_n_out) low++;
    end
    chk("wd_low_cycles", low, 4);
    rx_state_in = 2'b00;
    rx_valid_in = 1'b0;
    repeat (2) step();
    chk("wd_hold_no_capture", out_valid, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("wd_clr", timeout, 1'b0);

    // Receiver returns to idle before the limit twice: no timeout
    rst_min = 1;
    for (int r = 0; r < 2; r++) begin
      rx_state_in = 2'b11;
      strobes = 0;
      for (int c = 0; c < 1000 && strobes < 90; c++) begin
        step();
        if (rx_ena_out) strobes++;
        if (!rx_rst_n_out) rst_min = 0;
      end
      rx_state_in = 2'b00;
      step();
    end
    chk("nowd_timeout", timeout, 1'b0);
    chk("nowd_rst_high", rst_min, 1);

    // Reset mid-frame discards FIFO contents
    send(7'h7F);
    chk("midrst_pre_valid", out_valid, 1'b1);
    rx_valid_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 4'h0);
    chk("midrst_strobe", rx_ena_out, 1'b0);
    rx_valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("midrst_after_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
